// File: rtl/rr_capture_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_capture_arb
// Purpose  : Round-robin arbiter feeding one shared capture register. Each
//            cycle the register can take a word, the highest-priority active
//            requester (starting from an internal pointer) is granted, and its
//            data word is registered into q with a valid/ready handshake.
// Options  : RR_ARB_LOCK_EN - adds the lock port; a locked winner keeps top
//            priority for back-to-back bursts instead of passing it on.
// Revision : 1.0 - initial release
// ============================================================================
module rr_capture_arb #(
    parameter int NREQ = 2,
    parameter int DW   = 1,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]   gnt,
    output logic [DW-1:0]     q,
    output logic [DW-1:0]     q_n,
    output logic [PW-1:0]     q_src,
    output logic              q_valid,
    input  logic              q_ready
`ifdef RR_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]   lock
`endif
);

    // Index of the last requester, and NREQ widened to hold ptr+offset sums.
    localparam logic [PW-1:0] c_last = PW'(NREQ - 1);
    localparam logic [PW:0]   c_nreq = (PW + 1)'(NREQ);

    logic [DW-1:0] w_data_arr [NREQ];
    logic [PW-1:0] r_ptr;
    logic [DW-1:0] r_q;
    logic [PW-1:0] r_src;
    logic          r_valid;

    logic          w_accept;
    logic          w_found;
    logic          w_grant;
    logic [PW-1:0] w_winner;
    logic [PW:0]   w_idx;
    logic [PW-1:0] w_next_ptr;

    // Split the flattened data bus into one word per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_data_arr[i] = data[i*DW +: DW];
    end

    // The register can load whenever it is empty or being drained this cycle.
    assign w_accept = !r_valid || q_ready;
    assign w_grant  = w_accept && w_found && !rst;

    // Rotating priority scan: first active request at ptr, ptr+1, ... wrapping
    // modulo NREQ so non-power-of-two counts never yield an out-of-range index.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (PW + 1)'(k);
            if (w_idx >= c_nreq) begin
                w_idx = w_idx - c_nreq;
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    // One-hot grant, suppressed under back-pressure and while in reset.
    always_comb begin
        gnt = '0;
        if (w_grant) begin
            gnt[w_winner] = 1'b1;
        end
    end

    // Priority passes to the requester after the winner; a locked winner keeps it.
    always_comb begin
        w_next_ptr = (w_winner == c_last) ? '0 : w_winner + 1'b1;
`ifdef RR_ARB_LOCK_EN
        if (lock[w_winner]) begin
            w_next_ptr = w_winner;
        end
`endif
    end

    // Capture register and priority pointer; an empty accept cycle drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= '0;
            r_src   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            if (w_grant) begin
                r_q     <= w_data_arr[w_winner];
                r_src   <= w_winner;
                r_valid <= 1'b1;
                r_ptr   <= w_next_ptr;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign q       = r_q;
    assign q_n     = ~r_q;
    assign q_src   = r_src;
    assign q_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_capture_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_capture_arb
// Purpose  : Self-checking bench for rr_capture_arb (NREQ=3, DW=8). Directed
//            sequences followed by random traffic; a queue-based scoreboard
//            holds expected captured words, a monitor compares q each cycle.
// Options  : RR_ARB_LOCK_EN - also drives and models the lock port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_capture_arb;

    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int PW   = $clog2(NREQ);

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  data;
    logic [NREQ-1:0]     gnt;
    logic [DW-1:0]       q;
    logic [DW-1:0]       q_n;
    logic [PW-1:0]       q_src;
    logic                q_valid;
    logic                q_ready;
`ifdef RR_ARB_LOCK_EN
    logic [NREQ-1:0]     lock;
`endif

    rr_capture_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .q       (q),
        .q_n     (q_n),
        .q_src   (q_src),
        .q_valid (q_valid),
        .q_ready (q_ready)
`ifdef RR_ARB_LOCK_EN
        ,
        .lock    (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            src;
    } ent_t;

    // Scoreboard and reference-model state.
    ent_t          sb[$];
    bit            pend_pop;
    bit            m_valid;
    int            m_ptr;
    logic [DW-1:0] last_q;
    int            last_src;
    int            checks;
    int            failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the combinational
    // grant against the model, and record what the next rising edge must do.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d, input logic rdy);
        int            win;
        bit            acc;
        logic [NREQ-1:0] eg;
        ent_t          e;
        @(negedge clk);
        req     = r;
        data    = d;
        q_ready = rdy;
        #1;
        acc = !m_valid || rdy;
        win = -1;
        if (acc) begin
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && r[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
        end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        pend_pop = m_valid && rdy;
        if (acc) begin
            if (win >= 0) begin
                e.d   = d[win*DW +: DW];
                e.src = win;
                sb.push_back(e);
                m_valid = 1'b1;
                m_ptr   = (win + 1) % NREQ;
`ifdef RR_ARB_LOCK_EN
                if (lock[win]) m_ptr = win;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Assert reset mid-cycle, check reset values before any clock edge, then
    // hold across one rising edge and release with no requests pending.
    task automatic do_reset();
        @(negedge clk);
        req     = '1;
        q_ready = 1'b0;
        rst     = 1'b1;
        #1;
        sb.delete();
        pend_pop = 1'b0;
        m_valid  = 1'b0;
        m_ptr    = 0;
        last_q   = '0;
        last_src = 0;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_n", 32'(q_n), 32'(8'hFF));
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_q_src", 32'(q_src), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #2;
        req = '0;
        rst = 1'b0;
    endtask

    // Monitor: after every rising edge retire the consumed word and compare
    // the presented output against the scoreboard head.
    initial begin
        logic [DW-1:0] exp_qn;
        forever begin
            @(posedge clk);
            #1;
            if (pend_pop) begin
                if (sb.size() > 0) void'(sb.pop_front());
                pend_pop = 1'b0;
            end
            if (sb.size() > 0) begin
                last_q   = sb[0].d;
                last_src = sb[0].src;
            end
            exp_qn = ~last_q;
            chk("q_valid", 32'(q_valid), 32'(sb.size() != 0));
            chk("q", 32'(q), 32'(last_q));
            chk("q_n", 32'(q_n), 32'(exp_qn));
            chk("q_src", 32'(q_src), 32'(last_src));
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        pend_pop = 1'b0;
        m_valid  = 1'b0;
        m_ptr    = 0;
        last_q   = '0;
        last_src = 0;
        rst      = 1'b1;
        req      = '0;
        data     = '0;
        q_ready  = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock     = '0;
`endif
        do_reset();

        // Single requester after reset.
        step(3'b001, 24'h00003C, 1'b1);
        chk("t1_gnt", 32'(gnt), 32'h1);

        // Fairness between two requesters from a fresh pointer.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(3'b011, 24'h002211, 1'b1);
            chk("t2_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Back-pressure holds 0xA5, then release grants with no bubble.
        step(3'b001, 24'h0000A5, 1'b1);
        chk("t3_load", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(3'b011, 24'h005A77, 1'b0);
            chk("t3_hold_gnt", 32'(gnt), 32'h0);
        end
        step(3'b011, 24'h005A77, 1'b1);
        chk("t3_release_gnt", 32'(gnt), 32'h2);

        // Wrap-around: lone top requester, then all three rotate.
        for (int i = 0; i < 2; i++) begin
            step(3'b100, 24'hC30000 + 24'(i), 1'b1);
            chk("t4_top_gnt", 32'(gnt), 32'h4);
        end
        for (int i = 0; i < 4; i++) begin
            step(3'b111, 24'h332211, 1'b1);
            chk("t4_rot_gnt", 32'(gnt), 32'(3'b001 << (i % 3)));
        end

        // Reset in the middle of a stalled burst.
        step(3'b011, 24'h00EE99, 1'b0);
        chk("t5_stall_gnt", 32'(gnt), 32'h0);
        do_reset();
        step(3'b011, 24'h00EE99, 1'b1);
        chk("t5_post_rst_gnt", 32'(gnt), 32'h1);

`ifdef RR_ARB_LOCK_EN
        // Locked requester keeps priority until it transfers unlocked.
        do_reset();
        lock = 3'b001;
        for (int i = 0; i < 4; i++) begin
            step(3'b011, 24'h004411, 1'b1);
            chk("t6_lock_gnt", 32'(gnt), 32'h1);
        end
        lock = 3'b000;
        step(3'b011, 24'h004411, 1'b1);
        chk("t6_unlock_gnt0", 32'(gnt), 32'h1);
        step(3'b011, 24'h004411, 1'b1);
        chk("t6_unlock_gnt1", 32'(gnt), 32'h2);
`endif

        // Random traffic with random back-pressure and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
`ifdef RR_ARB_LOCK_EN
                lock = NREQ'($urandom_range(0, (1 << NREQ) - 1));
`endif
                step(NREQ'($urandom_range(0, (1 << NREQ) - 1)),
                     (NREQ*DW)'($urandom),
                     ($urandom_range(0, 3) != 0));
            end
        end

        // Drain so the monitor sees the final words leave.
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
